// File: rtl/uart_rx_core_if.sv
// Line-side and consumer-side signals of the UART receive core.
// With `UART_RX_PARITY_EN defined the bundle also carries ParityErr.
interface uart_rx_core_if;
    logic       Rx;
    logic       RxEn;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;
`ifdef UART_RX_PARITY_EN
    logic       ParityErr;

    modport master (output Rx, RxEn, input RxData, RxDone, FrameErr, Busy, ParityErr);
    modport slave  (input Rx, RxEn, output RxData, RxDone, FrameErr, Busy, ParityErr);
`else
    modport master (output Rx, RxEn, input RxData, RxDone, FrameErr, Busy);
    modport slave  (input Rx, RxEn, output RxData, RxDone, FrameErr, Busy);
`endif
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: majority vote per bit, false-start rejection, framing error and
// break hold-off. Defining `UART_RX_PARITY_EN adds an even-parity bit and ParityErr.
module uart_rx_core #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic           Clock,
    input logic           Reset,
    uart_rx_core_if.slave bus
);

    localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SampW = $clog2(OVERSAMPLE);

    localparam logic [DivW-1:0]  DivLast  = DivW'(DIV - 1);
    localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);
    localparam logic [SampW-1:0] VoteA    = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] VoteB    = SampW'(OVERSAMPLE / 2);
    localparam logic [SampW-1:0] VoteC    = SampW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [DivW-1:0]  div_q, div_d;
    logic [SampW-1:0] samp_q, samp_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       vote_q, vote_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    logic tick, mid_pt, bit_end, maj;

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        vote_d  = vote_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        tick    = (div_q == DivLast);
        div_d   = tick ? '0 : div_q + 1'b1;
        mid_pt  = tick && (samp_q == VoteC);
        bit_end = tick && (samp_q == SampLast);
        // Third vote is the live sample taken on the decision tick itself.
        maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) | (vote_q[1] & rx_sync_q);

        if (tick) begin
            samp_d = (samp_q == SampLast) ? '0 : samp_q + 1'b1;
            if (samp_q == VoteA) vote_d[0] = rx_sync_q;
            if (samp_q == VoteB) vote_d[1] = rx_sync_q;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.RxEn && !rx_sync_q) begin
                    // Realign bit phase to the detected falling edge.
                    state_d = StStart;
                    div_d   = '0;
                    samp_d  = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (mid_pt && maj) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (mid_pt) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (mid_pt) par_d = maj;
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (mid_pt) begin
                    if (maj) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^shift_q) ^ par_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        samp_d  = '0;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                // samp counts consecutive high ticks; any low tick restarts the bit time.
                if (tick) begin
                    if (!rx_sync_q) begin
                        samp_d = '0;
                    end else if (samp_q == SampLast) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            vote_q    <= 2'b11;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= bus.Rx;
            rx_sync_q <= rx_meta_q;
            div_q     <= div_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            vote_q    <= vote_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.RxData   = data_q;
    assign bus.RxDone   = done_q;
    assign bus.FrameErr = ferr_q;
    assign bus.Busy     = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign bus.ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus pushes expected pulses, a negedge monitor pops
// and compares them. Scaled clock/baud keep a frame at 80 clocks per bit.
module tb_uart_rx_core;

    localparam int unsigned ClkHz  = 8000000;
    localparam int unsigned Baud   = 100000;
    localparam int unsigned Os     = 16;
    localparam int unsigned BitClk = (ClkHz / (Baud * Os)) * Os;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif

    logic Clock = 1'b0;
    logic Reset;

    uart_rx_core_if bus ();

    uart_rx_core #(
        .CLK_HZ    (ClkHz),
        .BAUD      (Baud),
        .OVERSAMPLE(Os)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          is_done;
        logic [7:0]  data;
        bit          perr;
        int unsigned t0;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned done_cycles[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          busy_seen;
    logic [7:0]  last_good = 8'h00;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int unsigned act,
                               input int unsigned lo, input int unsigned hi);
        n_vec++;
        if (act < lo || act >= hi) begin
            n_err++;
            $display("FAIL %s: got %0d, required [%0d,%0d)", name, act, lo, hi);
        end
    endtask

    // Monitor: every RxDone/FrameErr pulse must match the oldest expected event.
    always @(negedge Clock) begin
        exp_t e;
        if (bus.Busy === 1'b1) busy_seen = 1'b1;
        if (bus.RxDone === 1'b1 || bus.FrameErr === 1'b1) begin
            check("pulse_exclusive", 32'(bus.RxDone & bus.FrameErr), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: RxDone=%b FrameErr=%b RxData=0x%0h, none expected",
                         bus.RxDone, bus.FrameErr, bus.RxData);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_done", 32'(bus.RxDone), 32'(e.is_done));
                check(e.is_done ? "rx_data" : "rx_data_kept", 32'(bus.RxData), 32'(e.data));
`ifdef UART_RX_PARITY_EN
                check("parity_err", 32'(bus.ParityErr), 32'(e.perr & e.is_done));
`endif
                // Decision falls in the second half of the stop bit.
                check_range("latency", cyc - e.t0, (2 * FrameBits - 1) * BitClk / 2,
                            FrameBits * BitClk);
                if (bus.RxDone === 1'b1) done_cycles.push_back(cyc);
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_bit(input logic b);
        bus.Rx = b;
        idle(BitClk);
    endtask

    // Call at a negedge. Pushes the expected event before driving the line.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                              input bit expect_it, input bit drop_en);
        exp_t e;
        if (expect_it) begin
            e.is_done = stop;
            e.data    = stop ? d : last_good;
            e.perr    = (^d) ^ pbit;
            e.t0      = cyc;
            exp_q.push_back(e);
            if (stop) last_good = d;
        end
        send_bit(1'b0);
        if (drop_en) bus.RxEn = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(pbit);
`endif
        send_bit(stop);
        if (drop_en) bus.RxEn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected events pending",
                 exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic        stop;
        logic        pbit;
        bit          drop;
        int unsigned gap;

        Reset  = 1'b0;
        bus.Rx = 1'b1;
        bus.RxEn = 1'b1;
        idle(3);
        check("reset_rx_data", 32'(bus.RxData), 32'h0);
        check("reset_rx_done", 32'(bus.RxDone), 32'h0);
        check("reset_frame_err", 32'(bus.FrameErr), 32'h0);
        check("reset_busy", 32'(bus.Busy), 32'h0);
        Reset = 1'b1;
        idle(10);

        send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(BitClk / 2);
        check("busy_after_0x41", 32'(bus.Busy), 32'h0);

        // Short low glitch: Busy rises, then false-start rejection.
        busy_seen = 1'b0;
        bus.Rx = 1'b0;
        idle(BitClk / 5);
        bus.Rx = 1'b1;
        idle(BitClk);
        check("false_start_busy_seen", 32'(busy_seen), 32'h1);
        check("false_start_busy_clear", 32'(bus.Busy), 32'h0);
        check("false_start_data_kept", 32'(bus.RxData), 32'(last_good));

        // Bad stop bit, then line held low: needs a full high bit time before IDLE.
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3 * BitClk);
        check("break_busy_low_line", 32'(bus.Busy), 32'h1);
        bus.Rx = 1'b1;
        idle(BitClk / 2);
        check("break_busy_half_bit", 32'(bus.Busy), 32'h1);
        idle(BitClk);
        check("break_released", 32'(bus.Busy), 32'h0);
        check("break_data_kept", 32'(bus.RxData), 32'h41);

        // Receiver disabled: line ignored entirely.
        bus.RxEn = 1'b0;
        busy_seen = 1'b0;
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 1'b0);
        idle(BitClk);
        check("disabled_busy", 32'(busy_seen), 32'h0);
        bus.RxEn = 1'b1;
        send_frame(8'h3C, 1'b1, ^8'h3C, 1'b1, 1'b0);
        idle(BitClk);

        // Back-to-back frames with no idle gap.
        done_cycles.delete();
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(BitClk);
        check("b2b_pulse_count", 32'(done_cycles.size()), 32'd2);
        if (done_cycles.size() == 2)
            check("b2b_spacing", done_cycles[1] - done_cycles[0], FrameBits * BitClk);

        // Reset in the middle of the data bits of 0x77.
        d = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        Reset  = 1'b0;
        bus.Rx = 1'b1;
        idle(1);
        check("midreset_rx_data", 32'(bus.RxData), 32'h0);
        check("midreset_rx_done", 32'(bus.RxDone), 32'h0);
        check("midreset_frame_err", 32'(bus.FrameErr), 32'h0);
        check("midreset_busy", 32'(bus.Busy), 32'h0);
        Reset = 1'b1;
        last_good = 8'h00;
        idle(BitClk);
        send_frame(8'h12, 1'b1, ^8'h12, 1'b1, 1'b0);
        idle(BitClk / 2);
        check("after_reset_data", 32'(bus.RxData), 32'h12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(BitClk / 2);
`endif

        // Randomised frames: gaps, occasional bad stop, RxEn dropped mid-frame.
        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            drop = ($urandom_range(0, 3) == 0);
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            gap  = $urandom_range(0, BitClk);
            send_frame(d, stop, pbit, 1'b1, drop);
            if (!stop) begin
                bus.Rx = 1'b1;
                idle(2 * BitClk);
            end
            bus.Rx = 1'b1;
            idle(gap);
        end

        for (int i = 0; i < int'(4 * FrameBits * BitClk); i++) begin
            if (exp_q.size() == 0) break;
            idle(1);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive stage that feeds the echo/test harness: it deserialises the asynchronous Rx line into bytes and hands each byte downstream as RxData with a one-cycle RxDone strobe.
- Oversampled, mid-bit majority sampling with false-start rejection and framing-error detection.
- Gated by RxEn so the consumer can hold off new frames.
- Sits between the board Rx pin and the byte consumer; the transmitter is a separate block.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 9600, line baud rate
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-low reset
Rx  input  1  asynchronous serial line, idle high
RxEn  input  1  receive enable; sampled only in IDLE
RxData  output  8  last correctly received byte, LSB first on the line
RxDone  output  1  one-cycle pulse when RxData is updated
FrameErr  output  1  one-cycle pulse on bad stop bit
Busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (Reset==0 at a Clock edge): RxData=0, RxDone=0, FrameErr=0, Busy=0, state=IDLE, tick/bit counters=0, synchroniser flops=1.
- Input path: 2-flop synchroniser on Rx. All decisions use the synchronised value rx_s.
- Tick generator: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation (50 MHz/9600/16 gives DIV=325, bit = 5200 clocks).
  - Counter width is $clog2(DIV).
  - Emits a 1-cycle tick every DIV clocks.
  - Restarted on start detection, so bit phase aligns to the falling edge.
- Sample counter counts ticks 0..OVERSAMPLE-1 within each bit. The bit value is the majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- IDLE:
  - If RxEn==1 and rx_s==0, go to START and set Busy=1.
  - If RxEn==0, the line is ignored entirely.
- START: at the majority point, a sampled 1 is a false start: go to IDLE with Busy=0 and no pulses. A sampled 0 proceeds to DATA at the bit boundary.
- DATA:
  - 8 bits; shift register fills LSB-first. A 3-bit bit index wraps 7 -> next state.
  - RxData is not touched during DATA.
- STOP: at the majority point:
  - Sampled 1: RxData <= shift register, RxDone=1 for exactly one cycle, go to IDLE (Busy=0) in the same cycle. The line need not finish the stop bit.
  - Sampled 0: FrameErr=1 for one cycle, RxData unchanged, go to BREAK.
- BREAK: wait until rx_s==1 for one full bit time (OVERSAMPLE consecutive ticks high), then go to IDLE. This prevents a held-low line from producing repeated frames.
- Latency: RxDone asserts about 9.5 bit times plus 3 clocks after the falling edge of the start bit on Rx.
- RxEn deasserted mid-frame: the frame completes normally and RxDone still pulses. The next frame is blocked.
- RxDone and FrameErr are never high in the same cycle.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded and no pulse is emitted.
- Back-to-back frames: a start edge that arrives immediately after stop-bit mid-sample is accepted (IDLE is re-entered before the next start bit's falling edge).

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP; parity is even, over the 8 data bits.
  - Adds output port ParityErr (1 bit, reset 0).
  - On mismatch at STOP with a good stop bit: ParityErr pulses 1 cycle alongside RxDone, and RxData is still updated.
- Undefined: 10-bit frame (8N1) with no PARITY state and no ParityErr port.

Test Plan:
- Reset low 3 cycles then high, Rx=1, RxEn=1; send 0x41 at 9600 baud -> one RxDone pulse; RxData=0x41; FrameErr=0; Busy low after the pulse.
- Rx pulled low for 1000 clocks then high, RxEn=1 -> Busy pulses high, then clears at false-start rejection; no RxDone; RxData unchanged.
- Send 0x55 with the stop bit driven 0, then hold Rx low 3 bit times, then high -> one FrameErr pulse; RxData keeps the previous 0x41; no new frame until Rx has been high 1 bit time.
- RxEn=0, send 0xA5 -> no RxDone, Busy stays 0. Set RxEn=1 and send 0x3C -> RxData=0x3C.
- Back-to-back 0x00 then 0xFF with no idle gap -> two RxDone pulses ~5200*10 clocks apart; RxData 0x00 then 0xFF.
- Reset driven low mid-DATA of 0x77 -> all outputs 0 next edge, no RxDone. Next frame 0x12 -> received correctly. With UART_RX_PARITY_EN, 0x07 sent with parity 0 -> RxDone plus ParityErr, RxData=0x07.
